// File: rtl/cursor_pkg.sv
// Shared definitions for the cursor packet scheduler: FSM encoding, click bit
// positions within the packet button byte, and the per-report motion limit.
package cursor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LATCH  = 2'd1,
      ST_STROBE = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;

   localparam int DX_MAX          = 127;
   localparam int CLICK_LEFT_BIT  = 0;
   localparam int CLICK_RIGHT_BIT = 1;
   localparam int CLICK_W         = 2;

endpackage

// File: rtl/cursor_axis_accum.sv
// One motion axis: saturating velocity accumulator, report clamp and remainder
// carry. Define CURSOR_DEADZONE_EN to drop samples with |vel| <= 2 raw LSBs.
module cursor_axis_accum
   import cursor_pkg::*;
#(
   parameter int FRAC_BITS = 4,
   parameter int ACC_W     = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              vel_valid,
   input  logic signed [15:0] vel,
   input  logic              latch,
   output logic signed [7:0] out,
   output logic              ovf
);

   localparam int SUM_W = ACC_W + 2;
   localparam logic signed [SUM_W-1:0] ACC_HI = {3'b000, {(ACC_W-1){1'b1}}};
   localparam logic signed [SUM_W-1:0] ACC_LO = {3'b111, {(ACC_W-1){1'b0}}};
   localparam logic signed [ACC_W-1:0] OUT_HI = ACC_W'(DX_MAX);
   localparam logic signed [ACC_W-1:0] OUT_LO = -OUT_HI;

   logic signed [ACC_W-1:0] acc_p1;
   logic signed [ACC_W-1:0] shifted;
   logic signed [SUM_W-1:0] acc_term;
   logic signed [SUM_W-1:0] vel_term;
   logic signed [SUM_W-1:0] rem_term;
   logic signed [SUM_W-1:0] sum;
   logic                    vld_p0;

   function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [SUM_W-1:0] v);
      if (v > ACC_HI)
         return ACC_HI[ACC_W-1:0];
      else if (v < ACC_LO)
         return ACC_LO[ACC_W-1:0];
      else
         return v[ACC_W-1:0];
   endfunction

   function automatic logic signed [7:0] clamp_out(input logic signed [ACC_W-1:0] s);
      if (s > OUT_HI)
         return 8'sd127;
      else if (s < OUT_LO)
         return -8'sd127;
      else
         return s[7:0];
   endfunction

`ifdef CURSOR_DEADZONE_EN
   assign vld_p0 = vel_valid && ((vel > 16'sd2) || (vel < -16'sd2));
`else
   assign vld_p0 = vel_valid;
`endif

   // Stage p0: reported count and next accumulator value, remainder carried forward
   always_comb begin
      shifted  = acc_p1 >>> FRAC_BITS;
      out      = clamp_out(shifted);
      acc_term = {{2{acc_p1[ACC_W-1]}}, acc_p1};
      vel_term = vld_p0 ? {{(SUM_W-16){vel[15]}}, vel} : '0;
      rem_term = latch ? ({{(SUM_W-8){out[7]}}, out} <<< FRAC_BITS) : '0;
      sum      = acc_term + vel_term - rem_term;
      ovf      = !clear && (vld_p0 || latch) && ((sum > ACC_HI) || (sum < ACC_LO));
   end

   // Stage p1: accumulator register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         acc_p1 <= '0;
      else if (clear)
         acc_p1 <= '0;
      else if (vld_p0 || latch)
         acc_p1 <= sat_acc(sum);
   end

endmodule

// File: rtl/cursor_packet_scheduler.sv
// Schedules 3-byte cursor report packets at the report tick rate, spaced by the
// UART packet time. Optional CURSOR_DEADZONE_EN enables the velocity deadzone.
module cursor_packet_scheduler
   import cursor_pkg::*;
#(
   parameter int REPORT_CLKS = 1000000,
   parameter int PACKET_CLKS = 26040,
   parameter int FRAC_BITS   = 4,
   parameter int ACC_W       = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              vel_valid,
   input  logic signed [15:0] vel_x,
   input  logic signed [15:0] vel_y,
   input  logic              left_req,
   input  logic              right_req,
   output logic              send_strobe,
   output logic signed [7:0] dx,
   output logic signed [7:0] dy,
   output logic              left_click,
   output logic              right_click,
   output logic              busy,
   output logic              acc_ovf
);

   localparam logic [31:0] TICK_LOAD = 32'(REPORT_CLKS - 1);
   localparam logic [31:0] HOLD_LOAD = 32'(PACKET_CLKS - 1);

   state_t              state;
   logic [31:0]         tick_cnt;
   logic [31:0]         hold_cnt;
   logic                tick;
   logic                pending;
   logic                latch;
   logic [CLICK_W-1:0]  new_clicks;
   logic [CLICK_W-1:0]  last_clicks;
   logic signed [7:0]   out_x;
   logic signed [7:0]   out_y;
   logic                ovf_x;
   logic                ovf_y;

   assign tick  = (tick_cnt == '0);
   assign latch = (state == ST_LATCH);

   always_comb begin
      new_clicks                  = '0;
      new_clicks[CLICK_LEFT_BIT]  = left_req;
      new_clicks[CLICK_RIGHT_BIT] = right_req;
   end

   cursor_axis_accum #(.FRAC_BITS(FRAC_BITS), .ACC_W(ACC_W)) u_axis_x (
      .clk       (clk),
      .rst       (rst),
      .clear     (!enable),
      .vel_valid (vel_valid),
      .vel       (vel_x),
      .latch     (latch),
      .out       (out_x),
      .ovf       (ovf_x)
   );

   cursor_axis_accum #(.FRAC_BITS(FRAC_BITS), .ACC_W(ACC_W)) u_axis_y (
      .clk       (clk),
      .rst       (rst),
      .clear     (!enable),
      .vel_valid (vel_valid),
      .vel       (vel_y),
      .latch     (latch),
      .out       (out_y),
      .ovf       (ovf_y)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         tick_cnt <= TICK_LOAD;
      else if (tick)
         tick_cnt <= TICK_LOAD;
      else
         tick_cnt <= tick_cnt - 32'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         pending     <= 1'b0;
         hold_cnt    <= '0;
         send_strobe <= 1'b0;
         dx          <= '0;
         dy          <= '0;
         left_click  <= 1'b0;
         right_click <= 1'b0;
         last_clicks <= '0;
         busy        <= 1'b0;
         acc_ovf     <= 1'b0;
      end else begin
         send_strobe <= 1'b0;
         if (ovf_x || ovf_y)
            acc_ovf <= 1'b1;
         // A tick that lands mid-packet is remembered once and serviced after HOLD
         if (!enable)
            pending <= 1'b0;
         else if (tick && state != ST_IDLE)
            pending <= 1'b1;

         case (state)
            ST_IDLE: begin
               if (enable && (tick || pending)) begin
                  state   <= ST_LATCH;
                  pending <= 1'b0;
                  busy    <= 1'b1;
               end
            end
            ST_LATCH: begin
               dx          <= out_x;
               dy          <= out_y;
               left_click  <= left_req;
               right_click <= right_req;
               if (out_x == 8'sd0 && out_y == 8'sd0 && new_clicks == last_clicks) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else begin
                  state       <= ST_STROBE;
                  send_strobe <= 1'b1;
                  last_clicks <= new_clicks;
               end
            end
            ST_STROBE: begin
               state    <= ST_HOLD;
               hold_cnt <= HOLD_LOAD;
            end
            ST_HOLD: begin
               if (hold_cnt == '0) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else begin
                  hold_cnt <= hold_cnt - 32'd1;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
